usb_rx_phy: RTL and testbench

USB_RX_PHY -- requirements
Module: usb_rx_phy

---
 rtl/usb_pkg.sv | 23 ++
 rtl/usb_rx_sync.sv | 34 +++
 rtl/usb_rx_phy.sv | 166 ++++++++++++++++
 tb/tb_usb_rx_phy.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared types for the USB full-speed receive path: line states, rx FSM states, sync pattern.
package usb_pkg;

  // Encoding is {D+, D-} so the synchronizer output maps directly.
  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_K   = 2'b01,
    LS_J   = 2'b10,
    LS_SE1 = 2'b11
  } line_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SYNC,
    RX_DATA,
    RX_ERROR
  } rx_state_e;

  // Decoded bits expected after the first K of sync; bit i is the i-th bit.
  localparam logic [6:0] SYNC_BITS = 7'b1000000;
  localparam logic [2:0] SYNC_LAST = 3'd6;

endpackage

// File: rtl/usb_rx_sync.sv
// Two-flop synchronizer for D+/D- plus line-state encoder (SE1 reported as J).
module usb_rx_sync
  import usb_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  d_plus_in,
  input  logic  d_minus_in,
  output line_e line_o
);

  logic [1:0] meta_q;
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 2'b10;
      sync_q <= 2'b10;
    end else begin
      meta_q <= {d_plus_in, d_minus_in};
      sync_q <= meta_q;
    end
  end

  always_comb begin
    line_o = LS_J;
    case (sync_q)
      2'b00:   line_o = LS_SE0;
      2'b01:   line_o = LS_K;
      default: line_o = LS_J;
    endcase
  end

endmodule

// File: rtl/usb_rx_phy.sv
// USB full-speed receive PHY: bit recovery, NRZI decode, sync detect, unstuffing, EOP.
// Optional: define USB_RX_STUFF_CHECK_EN to flag a stuff bit that decodes as 1.
module usb_rx_phy
  import usb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_plus_in,
  input  logic       d_minus_in,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       rx_active,
  output logic       rx_packet_done,
  output logic       rx_error,
  output rx_state_e  rx_state_dbg
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] WRAP = CW'(CLKS_PER_BIT - 1);

  line_e     line, line_q, samp_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  rx_state_e state_q, state_d;
  logic [2:0] sync_cnt_q, sync_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] ones_q, ones_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       se0_q, se0_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d, done_q, done_d, err_q, err_d;
  logic       sample, decoded;
  line_e      samp;

  usb_rx_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .d_plus_in  (d_plus_in),
    .d_minus_in (d_minus_in),
    .line_o     (line)
  );

  // cnt_q counts how long line_q has been stable, so line_q is the sampled state.
  assign cnt_d   = (line != line_q) ? '0 : ((cnt_q == WRAP) ? '0 : cnt_q + CW'(1));
  assign sample  = (cnt_q == HALF);
  assign samp    = line_q;
  assign decoded = (samp == samp_prev_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q      <= LS_J;
      samp_prev_q <= LS_J;
      cnt_q       <= '0;
      state_q     <= RX_IDLE;
      sync_cnt_q  <= '0;
      shift_q     <= '0;
      ones_q      <= '0;
      bit_cnt_q   <= '0;
      se0_q       <= 1'b0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      line_q      <= line;
      cnt_q       <= cnt_d;
      if (sample) samp_prev_q <= samp;
      state_q     <= state_d;
      sync_cnt_q  <= sync_cnt_d;
      shift_q     <= shift_d;
      ones_q      <= ones_d;
      bit_cnt_q   <= bit_cnt_d;
      se0_q       <= se0_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    shift_d    = shift_q;
    ones_d     = ones_q;
    bit_cnt_d  = bit_cnt_q;
    se0_d      = se0_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    if (sample) begin
      case (state_q)
        RX_IDLE: begin
          if (samp == LS_K) begin
            state_d    = RX_SYNC;
            sync_cnt_d = '0;
          end
        end
        RX_SYNC: begin
          if (samp == LS_SE0 || decoded != SYNC_BITS[sync_cnt_q]) begin
            state_d = RX_IDLE;
          end else if (sync_cnt_q == SYNC_LAST) begin
            state_d   = RX_DATA;
            shift_d   = '0;
            ones_d    = '0;
            bit_cnt_d = '0;
            se0_d     = 1'b0;
          end else begin
            sync_cnt_d = sync_cnt_q + 3'd1;
          end
        end
        RX_DATA: begin
          if (samp == LS_SE0) begin
            se0_d = 1'b1;
          end else if (se0_q) begin
            se0_d = 1'b0;
            if (samp == LS_J) begin
              state_d = RX_IDLE;
              done_d  = (bit_cnt_q == 3'd0);
              err_d   = (bit_cnt_q != 3'd0);
            end else begin
              state_d = RX_ERROR;
              err_d   = 1'b1;
            end
          end else if (ones_q == 3'd6) begin
            ones_d = '0;
`ifdef USB_RX_STUFF_CHECK_EN
            if (decoded) begin
              state_d = RX_ERROR;
              err_d   = 1'b1;
            end
`endif
          end else begin
            shift_d   = {decoded, shift_q[7:1]};
            ones_d    = decoded ? ones_q + 3'd1 : 3'd0;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              data_d  = {decoded, shift_q[7:1]};
              valid_d = 1'b1;
            end
          end
        end
        RX_ERROR: begin
          if (samp == LS_SE0) begin
            se0_d = 1'b1;
          end else begin
            se0_d = 1'b0;
            if (se0_q && samp == LS_J) state_d = RX_IDLE;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  assign rx_data        = data_q;
  assign rx_data_valid  = valid_q;
  assign rx_active      = (state_q == RX_DATA);
  assign rx_packet_done = done_q;
  assign rx_error       = err_q;
  assign rx_state_dbg   = state_q;

endmodule

// File: tb/tb_usb_rx_phy.sv
// Directed bench for usb_rx_phy: NRZI/stuffing line driver, strobe monitor, per-scenario checks.
module tb_usb_rx_phy;
  import usb_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       d_plus_in, d_minus_in;
  logic [7:0] rx_data;
  logic       rx_data_valid, rx_active, rx_packet_done, rx_error;
  rx_state_e  rx_state_dbg;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int done_cnt, err_cnt, multi_cnt;
  logic active_seen;
  logic alt_mode = 1'b0;
  logic alt_tog  = 1'b0;
  logic cur_k    = 1'b0;
  int   tb_ones  = 0;

  always #5 clk = ~clk;

  usb_rx_phy #(.CLKS_PER_BIT(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .d_plus_in      (d_plus_in),
    .d_minus_in     (d_minus_in),
    .rx_data        (rx_data),
    .rx_data_valid  (rx_data_valid),
    .rx_active      (rx_active),
    .rx_packet_done (rx_packet_done),
    .rx_error       (rx_error),
    .rx_state_dbg   (rx_state_dbg)
  );

  always @(negedge clk) begin
    if (rx_data_valid) got_q.push_back(rx_data);
    if (rx_packet_done) done_cnt++;
    if (rx_error) err_cnt++;
    if (rx_active) active_seen = 1'b1;
    if (int'(rx_data_valid) + int'(rx_packet_done) + int'(rx_error) > 1) multi_cnt++;
  end

  task automatic clear_mon();
    got_q.delete();
    exp_q.delete();
    done_cnt = 0; err_cnt = 0; multi_cnt = 0; active_seen = 1'b0;
  endtask

  task automatic get_len(output int n);
    if (alt_mode) begin
      alt_tog = !alt_tog;
      n = alt_tog ? 7 : 9;
    end else begin
      n = 8;
    end
  endtask

  task automatic drive_line(input logic dp, input logic dm, input int n);
    d_plus_in  = dp;
    d_minus_in = dm;
    repeat (n) @(posedge clk);
  endtask

  // NRZI: a 0 toggles the line, a 1 holds it.
  task automatic send_raw(input logic b);
    int n;
    get_len(n);
    if (!b) cur_k = !cur_k;
    drive_line(!cur_k, cur_k, n);
  endtask

  task automatic send_sync();
    cur_k = 1'b0;
    tb_ones = 0;
    for (int i = 0; i < 7; i++) send_raw(1'b0);
    send_raw(1'b1);
  endtask

  task automatic send_bits(input logic [15:0] v, input int nb);
    for (int i = 0; i < nb; i++) begin
      send_raw(v[i]);
      tb_ones = v[i] ? tb_ones + 1 : 0;
      if (tb_ones == 6) begin
        send_raw(1'b0);
        tb_ones = 0;
      end
    end
  endtask

  task automatic send_eop();
    int n;
    get_len(n); drive_line(1'b0, 1'b0, n);
    get_len(n); drive_line(1'b0, 1'b0, n);
    get_len(n); drive_line(1'b1, 1'b0, n);
    cur_k = 1'b0;
    drive_line(1'b1, 1'b0, 12);
  endtask

  task automatic check_bytes(input string name);
    chk_cnt++;
    if (got_q.size() !== exp_q.size()) $display("FAIL %s byte count: got %0d expected %0d", name, got_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk_cnt++;
      if (got_q[i] !== exp_q[i]) $display("FAIL %s byte %0d: got %02h expected %02h", name, i, got_q[i], exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; d_plus_in = 1'b1; d_minus_in = 1'b0;
    repeat (3) @(posedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_cnt++; if (rx_data !== 8'h00) $display("FAIL reset rx_data: got %02h expected 00", rx_data); else pass_cnt++;
    chk_cnt++; if ({rx_data_valid, rx_active, rx_packet_done, rx_error} !== 4'b0000)
      $display("FAIL reset strobes: got %b expected 0000", {rx_data_valid, rx_active, rx_packet_done, rx_error}); else pass_cnt++;
    chk_cnt++; if (rx_state_dbg !== RX_IDLE) $display("FAIL reset state: got %0d expected %0d", rx_state_dbg, RX_IDLE); else pass_cnt++;
    drive_line(1'b1, 1'b0, 16);
  endtask

  task automatic test_pid();
    clear_mon();
    exp_q.push_back(8'hC3);
    send_sync(); send_bits(16'h00C3, 8); send_eop();
    check_bytes("pid");
    chk_cnt++; if (done_cnt !== 1) $display("FAIL pid done: got %0d expected 1", done_cnt); else pass_cnt++;
    chk_cnt++; if (err_cnt !== 0) $display("FAIL pid error: got %0d expected 0", err_cnt); else pass_cnt++;
    chk_cnt++; if (active_seen !== 1'b1) $display("FAIL pid active_seen: got %b expected 1", active_seen); else pass_cnt++;
    chk_cnt++; if (rx_active !== 1'b0) $display("FAIL pid active after eop: got %b expected 0", rx_active); else pass_cnt++;
    chk_cnt++; if (multi_cnt !== 0) $display("FAIL pid strobe overlap: got %0d expected 0", multi_cnt); else pass_cnt++;
  endtask

  task automatic test_stuffing();
    clear_mon();
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    send_sync(); send_bits(16'h00FF, 16); send_eop();
    check_bytes("stuff");
    chk_cnt++; if (done_cnt !== 1) $display("FAIL stuff done: got %0d expected 1", done_cnt); else pass_cnt++;
    chk_cnt++; if (err_cnt !== 0) $display("FAIL stuff error: got %0d expected 0", err_cnt); else pass_cnt++;
  endtask

  task automatic test_seven_ones();
    clear_mon();
    send_sync();
    for (int i = 0; i < 7; i++) send_raw(1'b1);
`ifdef USB_RX_STUFF_CHECK_EN
    send_raw(1'b1); send_raw(1'b0);
    chk_cnt++; if (rx_state_dbg !== RX_ERROR) $display("FAIL seven_ones state: got %0d expected %0d", rx_state_dbg, RX_ERROR); else pass_cnt++;
    chk_cnt++; if (rx_active !== 1'b0) $display("FAIL seven_ones active: got %b expected 0", rx_active); else pass_cnt++;
    send_eop();
    chk_cnt++; if (err_cnt !== 1) $display("FAIL seven_ones error: got %0d expected 1", err_cnt); else pass_cnt++;
    chk_cnt++; if (done_cnt !== 0) $display("FAIL seven_ones done: got %0d expected 0", done_cnt); else pass_cnt++;
`else
    send_raw(1'b1); send_raw(1'b1);
    exp_q.push_back(8'hFF);
    send_eop();
    chk_cnt++; if (err_cnt !== 0) $display("FAIL seven_ones error: got %0d expected 0", err_cnt); else pass_cnt++;
    chk_cnt++; if (done_cnt !== 1) $display("FAIL seven_ones done: got %0d expected 1", done_cnt); else pass_cnt++;
`endif
    check_bytes("seven_ones");
    chk_cnt++; if (rx_state_dbg !== RX_IDLE) $display("FAIL seven_ones end state: got %0d expected %0d", rx_state_dbg, RX_IDLE); else pass_cnt++;
  endtask

  task automatic test_partial();
    clear_mon();
    exp_q.push_back(8'h3C);
    send_sync(); send_bits(16'h053C, 12); send_eop();
    check_bytes("partial");
    chk_cnt++; if (err_cnt !== 1) $display("FAIL partial error: got %0d expected 1", err_cnt); else pass_cnt++;
    chk_cnt++; if (done_cnt !== 0) $display("FAIL partial done: got %0d expected 0", done_cnt); else pass_cnt++;
    chk_cnt++; if (rx_data !== 8'h3C) $display("FAIL partial rx_data hold: got %02h expected 3c", rx_data); else pass_cnt++;
  endtask

  task automatic test_jitter();
    clear_mon();
    exp_q.push_back(8'hA5);
    alt_mode = 1'b1; alt_tog = 1'b0;
    send_sync(); send_bits(16'h00A5, 8); send_eop();
    alt_mode = 1'b0;
    check_bytes("jitter");
    chk_cnt++; if (done_cnt !== 1) $display("FAIL jitter done: got %0d expected 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_bad_sync();
    clear_mon();
    cur_k = 1'b0;
    send_raw(1'b0); send_raw(1'b0); send_raw(1'b0); send_raw(1'b1);
    cur_k = 1'b0;
    drive_line(1'b1, 1'b0, 40);
    chk_cnt++; if (active_seen !== 1'b0) $display("FAIL bad_sync active: got %b expected 0", active_seen); else pass_cnt++;
    chk_cnt++; if (got_q.size() + done_cnt + err_cnt !== 0) $display("FAIL bad_sync strobes: got %0d expected 0", got_q.size() + done_cnt + err_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    clear_mon();
    send_sync(); send_bits(16'h000B, 4);
    cur_k = 1'b0;
    d_plus_in = 1'b1; d_minus_in = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_cnt++; if ({rx_data_valid, rx_active, rx_packet_done, rx_error} !== 4'b0000)
      $display("FAIL reset_mid outputs: got %b expected 0000", {rx_data_valid, rx_active, rx_packet_done, rx_error}); else pass_cnt++;
    chk_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_mid rx_data: got %02h expected 00", rx_data); else pass_cnt++;
    drive_line(1'b1, 1'b0, 20);
    chk_cnt++; if (got_q.size() + done_cnt + err_cnt !== 0) $display("FAIL reset_mid strobes: got %0d expected 0", got_q.size() + done_cnt + err_cnt); else pass_cnt++;
    clear_mon();
    exp_q.push_back(8'hC3);
    send_sync(); send_bits(16'h00C3, 8); send_eop();
    check_bytes("reset_mid");
    chk_cnt++; if (done_cnt !== 1) $display("FAIL reset_mid done: got %0d expected 1", done_cnt); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_pid();
    test_stuffing();
    test_seven_ones();
    test_partial();
    test_jitter();
    test_bad_sync();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
